// File: rtl/dbus_demux2.sv
// Data-bus demux: routes one memory-stage request to data RAM (s0) or MMIO (s1)
// and returns the selected slave's response, with a response timeout.
module dbus_demux2 #(
    parameter int              AW      = 32,
    parameter int              DW      = 32,
    parameter logic [AW-1:0]   S1_BASE = 32'h1000_0000,
    parameter logic [AW-1:0]   S1_MASK = 32'hF000_0000,
    parameter int              TIMEOUT = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            m_req_valid,
    output logic            m_req_ready,
    input  logic [AW-1:0]   m_req_addr,
    input  logic            m_req_we,
    input  logic [DW-1:0]   m_req_wdata,
    input  logic [DW/8-1:0] m_req_wstrb,
    output logic            m_rsp_valid,
    output logic [DW-1:0]   m_rsp_rdata,
    output logic            m_rsp_err,
    output logic            s0_req_valid,
    input  logic            s0_req_ready,
    output logic [AW-1:0]   s0_req_addr,
    output logic            s0_req_we,
    output logic [DW-1:0]   s0_req_wdata,
    output logic [DW/8-1:0] s0_req_wstrb,
    input  logic            s0_rsp_valid,
    input  logic [DW-1:0]   s0_rsp_rdata,
    output logic            s1_req_valid,
    input  logic            s1_req_ready,
    output logic [AW-1:0]   s1_req_addr,
    output logic            s1_req_we,
    output logic [DW-1:0]   s1_req_wdata,
    output logic [DW/8-1:0] s1_req_wstrb,
    input  logic            s1_rsp_valid,
    input  logic [DW-1:0]   s1_rsp_rdata
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic              sel_q, sel_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              ready_q, ready_d;

    logic              sel_ready, sel_rsp;
    logic [DW-1:0]     sel_rdata;
    logic              tmo;

    assign sel_ready = sel_q ? s1_req_ready : s0_req_ready;
    assign sel_rsp   = sel_q ? s1_rsp_valid : s0_rsp_valid;
    assign sel_rdata = sel_q ? s1_rsp_rdata : s0_rsp_rdata;
    assign tmo       = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        we_d    = we_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (m_req_valid && ready_q) begin
                    addr_d  = m_req_addr;
                    we_d    = m_req_we;
                    wdata_d = m_req_wdata;
                    wstrb_d = m_req_wstrb;
                    sel_d   = ((m_req_addr & S1_MASK) == S1_BASE);
                    cnt_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // A response is only valid once the slave has taken the request
                if (sel_rsp && (state_q == WAIT || sel_ready)) begin
                    rdata_d = we_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                    state_d = RESP;
                end else if (tmo) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else if (state_q == ISSUE && sel_ready) begin
                    state_d = WAIT;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign ready_d = (state_d == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            ready_q <= ready_d;
        end
    end

    assign m_req_ready  = ready_q;
    assign m_rsp_valid  = (state_q == RESP);
    assign m_rsp_rdata  = rdata_q;
    assign m_rsp_err    = err_q;

    assign s0_req_valid = (state_q == ISSUE) && !sel_q;
    assign s0_req_addr  = sel_q ? '0 : addr_q;
    assign s0_req_we    = sel_q ? 1'b0 : we_q;
    assign s0_req_wdata = sel_q ? '0 : wdata_q;
    assign s0_req_wstrb = sel_q ? '0 : wstrb_q;

    assign s1_req_valid = (state_q == ISSUE) && sel_q;
    assign s1_req_addr  = sel_q ? addr_q : '0;
    assign s1_req_we    = sel_q ? we_q : 1'b0;
    assign s1_req_wdata = sel_q ? wdata_q : '0;
    assign s1_req_wstrb = sel_q ? wstrb_q : '0;

endmodule

// File: tb/tb_dbus_demux2.sv
// Directed bench for dbus_demux2: routing, wait states, timeout,
// stray responses and asynchronous reset.
module tb_dbus_demux2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m_req_valid, m_req_ready, m_req_we;
    logic [31:0] m_req_addr, m_req_wdata;
    logic [3:0]  m_req_wstrb;
    logic        m_rsp_valid, m_rsp_err;
    logic [31:0] m_rsp_rdata;
    logic        s0_req_valid, s0_req_ready, s0_req_we, s0_rsp_valid;
    logic [31:0] s0_req_addr, s0_req_wdata, s0_rsp_rdata;
    logic [3:0]  s0_req_wstrb;
    logic        s1_req_valid, s1_req_ready, s1_req_we, s1_rsp_valid;
    logic [31:0] s1_req_addr, s1_req_wdata, s1_rsp_rdata;
    logic [3:0]  s1_req_wstrb;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dbus_demux2 dut (
        .clk(clk), .rst_n(rst_n),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
        .m_req_addr(m_req_addr), .m_req_we(m_req_we),
        .m_req_wdata(m_req_wdata), .m_req_wstrb(m_req_wstrb),
        .m_rsp_valid(m_rsp_valid), .m_rsp_rdata(m_rsp_rdata),
        .m_rsp_err(m_rsp_err),
        .s0_req_valid(s0_req_valid), .s0_req_ready(s0_req_ready),
        .s0_req_addr(s0_req_addr), .s0_req_we(s0_req_we),
        .s0_req_wdata(s0_req_wdata), .s0_req_wstrb(s0_req_wstrb),
        .s0_rsp_valid(s0_rsp_valid), .s0_rsp_rdata(s0_rsp_rdata),
        .s1_req_valid(s1_req_valid), .s1_req_ready(s1_req_ready),
        .s1_req_addr(s1_req_addr), .s1_req_we(s1_req_we),
        .s1_req_wdata(s1_req_wdata), .s1_req_wstrb(s1_req_wstrb),
        .s1_rsp_valid(s1_rsp_valid), .s1_rsp_rdata(s1_rsp_rdata)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] ws);
        m_req_valid = 1'b1;
        m_req_addr  = a;
        m_req_we    = we;
        m_req_wdata = wd;
        m_req_wstrb = ws;
    endtask

    // Zero-wait load on s0: handshake at T, response pulse at T+3
    task automatic s0_load(input logic [31:0] a, input logic [31:0] d,
                           input string tg);
        req(a, 1'b0, 32'h0, 4'h0);
        check({tg, ".rdy_T"}, 64'(m_req_ready), 64'd1);
        step();
        m_req_valid = 1'b0;
        check({tg, ".s0v_T1"}, 64'(s0_req_valid), 64'd1);
        check({tg, ".s1v_T1"}, 64'(s1_req_valid), 64'd0);
        check({tg, ".s0a_T1"}, 64'(s0_req_addr), 64'(a));
        s0_req_ready = 1'b1;
        step();
        s0_req_ready = 1'b0;
        check({tg, ".s0v_T2"}, 64'(s0_req_valid), 64'd0);
        check({tg, ".rsp_T2"}, 64'(m_rsp_valid), 64'd0);
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = d;
        step();
        s0_rsp_valid = 1'b0;
        check({tg, ".rsp_T3"}, 64'(m_rsp_valid), 64'd1);
        check({tg, ".rdata"}, 64'(m_rsp_rdata), 64'(d));
        check({tg, ".err"}, 64'(m_rsp_err), 64'd0);
        check({tg, ".rdy_T3"}, 64'(m_req_ready), 64'd0);
        check({tg, ".s1v_T3"}, 64'(s1_req_valid), 64'd0);
        step();
        check({tg, ".rsp_T4"}, 64'(m_rsp_valid), 64'd0);
        check({tg, ".rdy_T4"}, 64'(m_req_ready), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        m_req_valid = 0; m_req_addr = 0; m_req_we = 0;
        m_req_wdata = 0; m_req_wstrb = 0;
        s0_req_ready = 0; s0_rsp_valid = 0; s0_rsp_rdata = 0;
        s1_req_ready = 0; s1_rsp_valid = 0; s1_rsp_rdata = 0;
        #12;
        check("rst.rdy", 64'(m_req_ready), 64'd0);
        check("rst.rsp", 64'(m_rsp_valid), 64'd0);
        check("rst.s0v", 64'(s0_req_valid), 64'd0);
        check("rst.rdata", 64'(m_rsp_rdata), 64'd0);
        step();
        rst_n = 1'b1;
        step();
        check("rel.rdy", 64'(m_req_ready), 64'd1);

        // basic load to RAM
        s0_load(32'h0000_0040, 32'hDEAD_BEEF, "t1");

        // timeout: s0 accepts but never responds
        req(32'h0000_0080, 1'b0, 32'h0, 4'h0);
        step();
        m_req_valid = 1'b0;
        s0_req_ready = 1'b1;
        step();
        s0_req_ready = 1'b0;
        for (int k = 2; k <= 16; k++) begin
            check("to.wait_rsp", 64'(m_rsp_valid), 64'd0);
            check("to.wait_rdy", 64'(m_req_ready), 64'd0);
            step();
        end
        check("to.rsp", 64'(m_rsp_valid), 64'd1);
        check("to.err", 64'(m_rsp_err), 64'd1);
        check("to.rdata", 64'(m_rsp_rdata), 64'd0);
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'h5555_5555;
        step();
        s0_rsp_valid = 1'b0;
        check("to.late_rsp", 64'(m_rsp_valid), 64'd0);
        check("to.err_hold", 64'(m_rsp_err), 64'd1);
        check("to.rdy", 64'(m_req_ready), 64'd1);
        step();
        check("to.late_rsp2", 64'(m_rsp_valid), 64'd0);

        // store to MMIO with 3 cycles of back-pressure
        req(32'h1000_0008, 1'b1, 32'h0000_00A5, 4'b0001);
        step();
        req(32'h0, 1'b0, 32'h0, 4'h0);
        m_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("st.s1v", 64'(s1_req_valid), 64'd1);
            check("st.s1a", 64'(s1_req_addr), 64'h1000_0008);
            check("st.s1d", 64'(s1_req_wdata), 64'h0000_00A5);
            check("st.s1s", 64'(s1_req_wstrb), 64'h1);
            check("st.s1we", 64'(s1_req_we), 64'd1);
            check("st.s0v", 64'(s0_req_valid), 64'd0);
            check("st.s0a", 64'(s0_req_addr), 64'd0);
            if (i == 3) s1_req_ready = 1'b1;
            step();
        end
        s1_req_ready = 1'b0;
        check("st.s1v_drop", 64'(s1_req_valid), 64'd0);
        s1_rsp_valid = 1'b1;
        s1_rsp_rdata = 32'hFFFF_FFFF;
        step();
        s1_rsp_valid = 1'b0;
        check("st.rsp", 64'(m_rsp_valid), 64'd1);
        check("st.rdata", 64'(m_rsp_rdata), 64'd0);
        check("st.err", 64'(m_rsp_err), 64'd0);
        step();
        check("st.rdy", 64'(m_req_ready), 64'd1);

        // stray response from the unselected slave
        req(32'h0000_0020, 1'b0, 32'h0, 4'h0);
        step();
        m_req_valid = 1'b0;
        s0_req_ready = 1'b1;
        step();
        s0_req_ready = 1'b0;
        s1_rsp_valid = 1'b1;
        s1_rsp_rdata = 32'h1234_5678;
        step();
        s1_rsp_valid = 1'b0;
        check("ws.no_rsp", 64'(m_rsp_valid), 64'd0);
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'h0000_0001;
        step();
        s0_rsp_valid = 1'b0;
        check("ws.rsp", 64'(m_rsp_valid), 64'd1);
        check("ws.rdata", 64'(m_rsp_rdata), 64'h1);
        step();

        // asynchronous reset while waiting on s1
        req(32'h1000_0010, 1'b0, 32'h0, 4'h0);
        step();
        m_req_valid = 1'b0;
        s1_req_ready = 1'b1;
        step();
        s1_req_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("ar.rdy", 64'(m_req_ready), 64'd0);
        check("ar.s1v", 64'(s1_req_valid), 64'd0);
        check("ar.s1a", 64'(s1_req_addr), 64'd0);
        check("ar.rdata", 64'(m_rsp_rdata), 64'd0);
        check("ar.err", 64'(m_rsp_err), 64'd0);
        check("ar.rsp", 64'(m_rsp_valid), 64'd0);
        s1_rsp_valid = 1'b1;
        s1_rsp_rdata = 32'h0000_0099;
        step();
        step();
        rst_n = 1'b1;
        step();
        s1_rsp_valid = 1'b0;
        check("ar.rel_rdy", 64'(m_req_ready), 64'd1);
        check("ar.rel_rsp", 64'(m_rsp_valid), 64'd0);
        check("ar.rel_rdata", 64'(m_rsp_rdata), 64'd0);
        s0_load(32'h0000_0044, 32'hA1B2_C3D4, "t5");

        // response coincides with the last timeout cycle
        req(32'h0000_0060, 1'b0, 32'h0, 4'h0);
        step();
        m_req_valid = 1'b0;
        check("rt.rdy_iss", 64'(m_req_ready), 64'd0);
        s0_req_ready = 1'b1;
        step();
        s0_req_ready = 1'b0;
        for (int k = 2; k <= 15; k++) begin
            check("rt.rdy_wait", 64'(m_req_ready), 64'd0);
            check("rt.no_rsp", 64'(m_rsp_valid), 64'd0);
            step();
        end
        check("rt.rdy_last", 64'(m_req_ready), 64'd0);
        s0_rsp_valid = 1'b1;
        s0_rsp_rdata = 32'hCAFE_F00D;
        step();
        s0_rsp_valid = 1'b0;
        check("rt.rsp", 64'(m_rsp_valid), 64'd1);
        check("rt.err", 64'(m_rsp_err), 64'd0);
        check("rt.rdata", 64'(m_rsp_rdata), 64'hCAFE_F00D);
        check("rt.rdy_resp", 64'(m_req_ready), 64'd0);
        step();
        check("rt.rsp_end", 64'(m_rsp_valid), 64'd0);
        check("rt.rdy_idle", 64'(m_req_ready), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
